// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the load/store unit and its counters.
package cpu_mem_pkg;

    // Width of the completed-operation counters.
    localparam int unsigned CNT_W = 16;

    // Load/store sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with increment enable.
module sat_counter
    import cpu_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count enabled events, holding at the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between execute and a synchronous data memory.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr,
    input  logic [DW-1:0]    req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_write,
    output logic [DW-1:0]    resp_rdata,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_read,
    output logic             mem_write,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    state_e        r_state;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_write;

    logic w_done;
    logic w_rd_inc;
    logic w_wr_inc;

    // Sequencer: capture request, one memory cycle, then hold response until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_write <= req_write;
                        // Stores report zero read data.
                        r_rdata <= '0;
                        r_state <= req_write ? WR : RD;
                    end
                end
                RD: begin
                    r_rdata <= mem_rdata;
                    r_state <= RESP;
                end
                WR: begin
                    r_state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Memory strobes come only from the state register so reset drops them at once.
    assign mem_read   = (r_state == RD);
    assign mem_write  = (r_state == WR);
    assign mem_addr   = r_addr;
    assign mem_wdata  = mem_write ? r_wdata : '0;

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_write = r_write;
    assign resp_rdata = r_rdata;

    assign w_done   = resp_valid && resp_ready;
    assign w_rd_inc = w_done && !r_write;
    assign w_wr_inc = w_done && r_write;

    sat_counter u_rd_count (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_rd_inc),
        .o_count (rd_count)
    );

    sat_counter u_wr_count (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_wr_inc),
        .o_count (wr_count)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases, random traffic, counter saturation.
module tb_mem_access_unit;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic          resp_write;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;

    logic          sat_en = 1'b0;
    logic [15:0]   sat_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_write (resp_write),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    // Standalone counter instance so saturation is reachable within the cycle budget.
    sat_counter u_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (sat_en),
        .o_count (sat_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory: combinational read, commit on the rising edge; garbage when not reading.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem_read ? mem[mem_addr] : ~mem[mem_addr];

    // Transaction-level reference: one op in flight, age counts cycles since acceptance.
    logic [DW-1:0] ref_mem [256];
    bit            m_busy;
    int            m_age;
    bit            m_op;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    int            m_rd;
    int            m_wr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_age = 0; m_op = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
            m_rd = 0; m_wr = 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1; m_age = 1; m_op = req_write;
                m_addr = req_addr; m_wdata = req_wdata; m_rdata = '0;
            end
        end else if (m_age == 1) begin
            m_age = 2;
            if (m_op) ref_mem[m_addr] = m_wdata;
            else m_rdata = ref_mem[m_addr];
        end else if (resp_ready) begin
            m_busy = 0;
            if (m_op) m_wr = (m_wr < 65535) ? m_wr + 1 : m_wr;
            else m_rd = (m_rd < 65535) ? m_rd + 1 : m_rd;
        end
    end

    // Compare DUT against the reference every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("req_ready", req_ready, !m_busy);
            check("resp_valid", resp_valid, m_busy && m_age >= 2);
            if (m_busy && m_age >= 2) begin
                check("resp_write", resp_write, m_op);
                check("resp_rdata", resp_rdata, m_op ? '0 : m_rdata);
            end
            check("mem_read", mem_read, m_busy && m_age == 1 && !m_op);
            check("mem_write", mem_write, m_busy && m_age == 1 && m_op);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, (m_busy && m_age == 1 && m_op) ? m_wdata : '0);
            check("rd_count", rd_count, m_rd);
            check("wr_count", wr_count, m_wr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        tick();
        req_valid = 0;
        for (int i = 0; i < 10 && !req_ready; i++) tick();
        check("op_done", req_ready, 1);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        #12;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wr_count", wr_count, 0);
        #5 rst_n = 1;
        cmp_en = 1;

        // Store 0x5A to 0x10.
        tick();
        req_valid = 1; req_write = 1; req_addr = 8'h10; req_wdata = 8'h5A;
        tick();
        req_valid = 0;
        check("st_mem_write", mem_write, 1);
        check("st_mem_addr", mem_addr, 8'h10);
        check("st_mem_wdata", mem_wdata, 8'h5A);
        check("st_req_ready", req_ready, 0);
        tick();
        check("st_resp_valid", resp_valid, 1);
        check("st_resp_write", resp_write, 1);
        check("st_mem_write_drop", mem_write, 0);
        tick();
        check("st_resp_done", resp_valid, 0);
        check("st_wr_count", wr_count, 1);
        check("st_mem_commit", mem[8'h10], 8'h5A);

        // Load 0x10 back.
        req_valid = 1; req_write = 0; req_addr = 8'h10;
        tick();
        req_valid = 0;
        check("ld_mem_read", mem_read, 1);
        check("ld_mem_addr", mem_addr, 8'h10);
        tick();
        check("ld_resp_rdata", resp_rdata, 8'h5A);
        check("ld_resp_write", resp_write, 0);
        tick();
        check("ld_rd_count", rd_count, 1);

        // Load with backpressure; a store presented meanwhile must be ignored.
        resp_ready = 0;
        req_valid = 1; req_write = 0; req_addr = 8'h10;
        tick();
        req_valid = 1; req_write = 1; req_addr = 8'h10; req_wdata = 8'h11;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", resp_valid, 1);
            check("bp_resp_rdata", resp_rdata, 8'h5A);
            check("bp_req_ready", req_ready, 0);
            tick();
        end
        req_valid = 0;
        resp_ready = 1;
        tick();
        check("bp_done", resp_valid, 0);
        check("bp_rd_count", rd_count, 2);
        check("bp_wr_count", wr_count, 1);
        check("bp_no_store", mem[8'h10], 8'h5A);

        // Reset in the middle of a store.
        do_op(1, 8'h20, 8'h33);
        req_valid = 1; req_write = 1; req_addr = 8'h20; req_wdata = 8'hFF;
        tick();
        req_valid = 0;
        check("rw_mem_write", mem_write, 1);
        #2 rst_n = 0;
        #1;
        check("rw_mem_write_drop", mem_write, 0);
        check("rw_wr_count", wr_count, 0);
        check("rw_req_ready", req_ready, 1);
        #3 rst_n = 1;
        req_valid = 1; req_write = 0; req_addr = 8'h20;
        tick();
        req_valid = 0;
        tick();
        check("rw_old_data", resp_rdata, 8'h33);
        tick();
        check("rw_rd_count", rd_count, 1);
        check("rw_wr_count2", wr_count, 0);

        // Reset while a response is pending.
        resp_ready = 0;
        req_valid = 1; req_write = 0; req_addr = 8'h20;
        tick();
        req_valid = 0;
        tick();
        check("rr_resp_valid", resp_valid, 1);
        #2 rst_n = 0;
        #1;
        check("rr_resp_drop", resp_valid, 0);
        check("rr_rd_count", rd_count, 0);
        #3 rst_n = 1;
        resp_ready = 1;
        tick();
        check("rr_req_ready", req_ready, 1);
        check("rr_rd_count2", rd_count, 0);

        // Random traffic over a small address window to hit store/load pairs.
        for (int c = 0; c < 2000; c++) begin
            tick();
            req_valid  = ($urandom_range(0, 2) != 0);
            req_write  = $urandom_range(0, 1) == 1;
            req_addr   = AW'($urandom_range(0, 15));
            req_wdata  = DW'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_n = 0;
                #3 rst_n = 1;
            end
        end
        req_valid = 0;
        resp_ready = 1;
        tick();
        tick();
        tick();

        // Counter saturation.
        check("sat_start", sat_count, 0);
        sat_en = 1;
        for (int i = 0; i < 65534; i++) tick();
        check("sat_fffe", sat_count, 16'hFFFE);
        tick();
        check("sat_ffff", sat_count, 16'hFFFF);
        tick();
        check("sat_hold", sat_count, 16'hFFFF);
        sat_en = 0;
        tick();

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
